// File: rtl/rapcore_pkg.sv
// rapcore_pkg: register map, CTRL/STATUS bit positions and SPI FSM encoding.
package rapcore_pkg;
  localparam logic [2:0] OFF_TX_LO = 3'd0;
  localparam logic [2:0] OFF_TX_HI = 3'd1;
  localparam logic [2:0] OFF_RX_LO = 3'd2;
  localparam logic [2:0] OFF_RX_HI = 3'd3;
  localparam logic [2:0] OFF_CTRL  = 3'd4;
  localparam int CTRL_START    = 0;
  localparam int CTRL_HOLD_CS  = 1;
  localparam int CTRL_DONE_CLR = 2;
  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_HOLD_CS = 2;
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, SHIFT = 2'd2, HOLD = 2'd3} spi_state_t;
  function automatic logic [31:0] apply_sel(input logic [31:0] old, input logic [31:0] data,
                                            input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (sel[i]) r[8*i +: 8] = data[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: mode-0 SPI shifter with SCK divider, bit counter and chip-select control.
module spi_shift_engine
  import rapcore_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int WORD_BITS = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 hold_cs,
  input  logic                 cipo,
  input  logic [WORD_BITS-1:0] tx,
  output logic [WORD_BITS-1:0] rx,
  output logic                 sck,
  output logic                 cs,
  output logic                 copi,
  output logic                 busy,
  output logic                 done
);
  localparam int CW = $clog2(WORD_BITS);
  localparam logic [8:0] HALF = 9'(CLK_DIV);
  localparam logic [8:0] LAST = 9'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WORD_BITS - 1);
  spi_state_t state, state_n;
  logic [8:0] div;
  logic [CW-1:0] cnt;
  logic [WORD_BITS-1:0] sr;
  logic rx_bit, cs_q, setup_end, rise, fall, hold_end;
  always_comb begin
    setup_end = state == SETUP && div == HALF - 9'd1;
    rise      = state == SHIFT && div == HALF - 9'd1;
    fall      = state == SHIFT && div == LAST;
    hold_end  = state == HOLD && div == HALF - 9'd1;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = (state == IDLE && start) ? SETUP :
              setup_end ? SHIFT :
              (fall && cnt == LAST_BIT) ? HOLD :
              hold_end ? IDLE : state;
  end
  // The received bit sampled on the rising edge enters the shifter on the following falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      div    <= '0;
      cnt    <= '0;
      sr     <= '0;
      rx_bit <= 1'b0;
      cs_q   <= 1'b1;
    end else begin
      div    <= (state_n != state || fall || state == IDLE) ? 9'd0 : div + 9'd1;
      cnt    <= (state == IDLE) ? '0 : (fall && cnt != LAST_BIT) ? cnt + CW'(1) : cnt;
      if (state == IDLE && start) sr <= tx;
      else if (fall) sr <= {sr[WORD_BITS-2:0], rx_bit};
      if (rise) rx_bit <= cipo;
      cs_q   <= (state == IDLE) ? (start ? 1'b0 : (cs_q | ~hold_cs)) : hold_end ? ~hold_cs : cs_q;
    end
  end
  always_comb begin
    busy = state != IDLE;
    sck  = state == SHIFT && div >= HALF;
    copi = busy & sr[WORD_BITS-1];
    cs   = cs_q;
    done = hold_end;
    rx   = sr;
  end
endmodule

// File: rtl/rapcore_spi_host.sv
// rapcore_spi_host: Wishbone-controlled SPI host for the rapcore 64-bit command interface.
module rapcore_spi_host
  import rapcore_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int WORD_BITS = 64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        sck_o,
  output logic        cs_o,
  output logic        copi_o,
  input  logic        cipo_i,
  output logic        busy_o
);
  logic [31:0] tx_lo, tx_hi, rx_lo, rx_hi, status, rd;
  logic [63:0] tx_word;
  logic [WORD_BITS-1:0] rx_word;
  logic [2:0] off;
  logic hold_cs, done, done_p, acc, wr, ctrl_wr, start, done_clr, unused_adr;
  // A request is taken only when no ack is outstanding, so a held strobe never double-acks.
  always_comb begin
    off        = wbs_adr_i[4:2];
    unused_adr = ^{wbs_adr_i[31:5], wbs_adr_i[1:0]};
    acc        = wbs_cyc_i && wbs_stb_i && !wbs_ack_o;
    wr         = acc && wbs_we_i;
    ctrl_wr    = wr && off == OFF_CTRL && wbs_sel_i[0];
    start      = ctrl_wr && wbs_dat_i[CTRL_START];
    done_clr   = ctrl_wr && wbs_dat_i[CTRL_DONE_CLR];
    tx_word    = {tx_hi, tx_lo};
    status               = '0;
    status[ST_BUSY]      = busy_o;
    status[ST_DONE]      = done;
    status[ST_HOLD_CS]   = hold_cs;
    rd = off == OFF_TX_LO ? tx_lo : off == OFF_TX_HI ? tx_hi : off == OFF_RX_LO ? rx_lo :
         off == OFF_RX_HI ? rx_hi : off == OFF_CTRL ? status : 32'd0;
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      tx_lo     <= '0;
      tx_hi     <= '0;
      rx_lo     <= '0;
      rx_hi     <= '0;
      hold_cs   <= 1'b0;
      done      <= 1'b0;
    end else begin
      wbs_ack_o <= acc;
      if (acc) wbs_dat_o <= rd;
      if (wr && off == OFF_TX_LO && !busy_o) tx_lo <= apply_sel(tx_lo, wbs_dat_i, wbs_sel_i);
      if (wr && off == OFF_TX_HI && !busy_o) tx_hi <= apply_sel(tx_hi, wbs_dat_i, wbs_sel_i);
      if (ctrl_wr) hold_cs <= wbs_dat_i[CTRL_HOLD_CS];
      done <= done_p | (done & ~done_clr);
      if (done_p) {rx_hi, rx_lo} <= 64'(rx_word);
    end
  end
  spi_shift_engine #(.CLK_DIV(CLK_DIV), .WORD_BITS(WORD_BITS)) u_engine (
    .clk(wb_clk_i), .rst(wb_rst_i), .start(start), .hold_cs(hold_cs), .cipo(cipo_i),
    .tx(tx_word[WORD_BITS-1:0]), .rx(rx_word), .sck(sck_o), .cs(cs_o), .copi(copi_o),
    .busy(busy_o), .done(done_p)
  );
endmodule

// File: doc/rapcore_spi_host.md
RAPCORE_SPI_HOST -- requirements
Module: rapcore_spi_host

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCK half-period in wb_clk_i cycles; legal range 2..255.
REQ-002 SHALL have parameter WORD_BITS, default 64: bits per SPI transfer, matching the rapcore command word.
REQ-003 SHALL have port wb_clk_i, input, 1: sole clock; all logic on its rising edge.
REQ-004 SHALL have port wb_rst_i, input, 1: synchronous, active-high reset.
REQ-005 SHALL have Wishbone slave ports wbs_stb_i, wbs_cyc_i, wbs_we_i (inputs, 1 bit each); wbs_sel_i (input, 4); wbs_dat_i (input, 32); wbs_adr_i (input, 32).
REQ-006 SHALL have Wishbone outputs wbs_ack_o (1) and wbs_dat_o (32).
REQ-007 SHALL have SPI controller ports sck_o, cs_o, copi_o (outputs, 1 bit each) and cipo_i (input, 1), to be wired to rapcore SCK/CS/COPI/CIPO.
REQ-008 SHALL have port busy_o, output, 1: high while a transfer is in progress.

Function
REQ-009 SHALL decode wbs_adr_i[4:2]: 0 TX_LO, 1 TX_HI, 2 RX_LO (read-only), 3 RX_HI (read-only), 4 CTRL/STATUS; all other offsets read 0 and ignore writes.
REQ-010 SHALL treat a request as valid when wbs_cyc_i && wbs_stb_i; wbs_ack_o pulses high exactly one cycle after a valid cycle, and never on two consecutive cycles.
REQ-011 SHALL apply writes per byte according to wbs_sel_i; wbs_dat_o is registered and valid in the ack cycle.
REQ-012 SHALL ignore writes to TX_LO/TX_HI while busy_o is high, but still acknowledge them.
REQ-013 CTRL write: bit0 START (self-clearing), bit1 HOLD_CS, bit2 DONE_CLR; STATUS read: bit0 busy, bit1 DONE (sticky), bit2 HOLD_CS.
REQ-014 SHALL use SPI mode 0: sck_o idles low; copi_o changes on SCK falling edges or on the first launch; cipo_i is sampled on SCK rising edges; MSB (TX_HI[31]) is sent first.
REQ-015 FSM states SHALL be IDLE, SETUP, SHIFT, HOLD.
REQ-016 IDLE -> SETUP on START while idle: cs_o goes low, copi_o = TX MSB, and the shift register loads {TX_HI,TX_LO}.
REQ-017 SETUP lasts CLK_DIV cycles, then enters SHIFT.
REQ-018 SHIFT SHALL produce WORD_BITS SCK periods of 2*CLK_DIV cycles each, with the low phase first.
REQ-019 SHIFT -> HOLD after the final falling edge; HOLD lasts CLK_DIV cycles, then -> IDLE.
REQ-020 On HOLD exit, RX_HI/RX_LO SHALL update with the received word, DONE SHALL set, and cs_o SHALL return high unless HOLD_CS=1.
REQ-021 START while busy SHALL be ignored and SHALL not set any error.
REQ-022 START and DONE_CLR in the same write: DONE SHALL clear, then the transfer starts.
REQ-023 When DONE set and DONE_CLR coincide on the same cycle, set SHALL win.
REQ-024 A bit counter SHALL count 0..WORD_BITS-1 with no wrap past the final bit.
REQ-025 The SCK divider SHALL reset to 0 on every state entry.
REQ-026 busy_o = (state != IDLE).
REQ-027 With HOLD_CS=1, cs_o SHALL stay low between back-to-back transfers, and the next START re-enters SETUP with cs_o already low.
REQ-028 Clearing HOLD_CS while in IDLE SHALL raise cs_o on the next cycle.

Reset
REQ-029 On wb_rst_i: state IDLE; sck_o=0, cs_o=1, copi_o=0, busy_o=0, wbs_ack_o=0, wbs_dat_o=0; TX/RX/CTRL registers 0.
REQ-030 Reset mid-transfer SHALL abort the transfer: the next edge gives cs_o=1 and sck_o=0, and no RX update occurs.

Structure
REQ-031 Register offsets, CTRL/STATUS bit positions and FSM state encoding SHALL live in the shared package rapcore_pkg.
REQ-032 SHALL instantiate exactly one sub-module, spi_shift_engine, holding the divider, bit counter and shift register; the Wishbone decode stays in the top module.

Verification
REQ-033 Write TX_HI=0xDEADBEEF, TX_LO=0x01234567, CTRL=1, with a loopback cipo_i=copi_o -> 64 SCK rising edges; RX_HI=0xDEADBEEF, RX_LO=0x01234567; DONE=1.
REQ-034 CLK_DIV=4: START ack -> cs_o falls within 2 cycles; first SCK rise 8 cycles after cs_o falls; total cs_o low = 4+512+4 cycles.
REQ-035 Write CTRL=1 during a busy transfer, plus TX_LO=0xFFFFFFFF -> both acked; TX_LO unchanged; only one transfer occurs.
REQ-036 Assert wb_rst_i at bit 20 -> the next cycle gives cs_o=1, sck_o=0, busy_o=0; RX stays 0.
REQ-037 HOLD_CS=1 with two STARTs -> cs_o stays low throughout; write CTRL=0 -> cs_o high the next cycle.
REQ-038 Byte write with sel=0b0100 and data 0x00AB0000 to TX_LO -> TX_LO reads 0x00AB0000 from reset; read offset 6 -> 0.
